// File: rtl/agc_pkg.sv
// agc_pkg: shared AGC arithmetic helpers and window-counter state encoding.
package agc_pkg;

    localparam int SCALE_BITS = 17;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} cnt_state_t;

    function automatic int q_sum(input int q_dat, input int q_offset);
        return (q_dat > q_offset) ? q_dat : q_offset;
    endfunction

    function automatic int lsb_pos(input int qs, input int q_scale, input int scale_in, input int nfrac_out);
        return qs + q_scale + scale_in - nfrac_out;
    endfunction

    // Ones on every product bit that must match the sign for the lane to fit.
    function automatic logic [127:0] sat_mask(input int pw, input int top);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 128; i++) m[i] = (i >= top) && (i < pw);
        return m;
    endfunction

endpackage

// File: rtl/agc_lane_sat.sv
// agc_lane_sat: per-lane floor-truncate and saturate of the scaled product, registered.
module agc_lane_sat
    import agc_pkg::*;
#(
    parameter int PW    = 39,
    parameter int LSB   = 23,
    parameter int NBITS = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic signed [PW-1:0]   prod,
    output logic [NBITS-1:0]       lane_out,
    output logic [NBITS-2:0]       mag,
    output logic                   gt,
    output logic                   lt
);

    localparam logic [PW-1:0]    MASK    = PW'(sat_mask(PW, LSB + NBITS - 1));
    localparam logic [NBITS-1:0] POS_MAX = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic [NBITS-1:0] NEG_MAX = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-2:0] MAG_MAX = '1;

    logic             neg;
    logic             ovf;
    logic [NBITS-1:0] val;
    logic [NBITS-2:0] inv;
    logic [NBITS-2:0] mag_n;

    always_comb begin
        neg   = prod[PW-1];
        ovf   = (prod & MASK) != (neg ? MASK : '0);
        val   = ovf ? (neg ? NEG_MAX : POS_MAX) : prod[LSB +: NBITS];
        inv   = -val[NBITS-2:0];
        mag_n = (val == NEG_MAX) ? MAG_MAX : (val[NBITS-1] ? inv : val[NBITS-2:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_out <= '0;
            mag      <= '0;
            gt       <= 1'b0;
            lt       <= 1'b0;
        end else begin
            lane_out <= val;
            mag      <= mag_n;
            gt       <= ovf & ~neg;
            lt       <= ovf & neg;
        end
    end

endmodule

// File: rtl/agc_multilane_scaler.sv
// agc_multilane_scaler: shared (data + offset) * scale across NSAMP lanes, with a
// staged/apply coefficient handshake and a windowed per-direction clip counter.
module agc_multilane_scaler
    import agc_pkg::*;
#(
    parameter int NSAMP       = 8,
    parameter int DAT_BITS    = 12,
    parameter int Q_DAT       = 0,
    parameter int OFFSET_BITS = 16,
    parameter int Q_OFFSET    = 8,
    parameter int Q_SCALE     = 12,
    parameter int SCALE_IN    = 5,
    parameter int NFRAC_OUT   = 2,
    parameter int NBITS       = 5,
    parameter int CNT_BITS    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [NSAMP*DAT_BITS-1:0]    dat_i,
    input  logic [SCALE_BITS-1:0]        scale_i,
    input  logic                         scale_wr_i,
    input  logic [OFFSET_BITS-1:0]       offset_i,
    input  logic                         offset_wr_i,
    input  logic                         apply_req_i,
    output logic                         apply_ack_o,
    output logic [NSAMP*NBITS-1:0]       out_o,
    output logic [NSAMP*(NBITS-1)-1:0]   abs_o,
    output logic [NSAMP-1:0]             gt_o,
    output logic [NSAMP-1:0]             lt_o,
    input  logic [CNT_BITS-1:0]          win_len_i,
    input  logic                         win_start_i,
    output logic [CNT_BITS-1:0]          hi_cnt_o,
    output logic [CNT_BITS-1:0]          lo_cnt_o,
    output logic                         cnt_valid_o,
    output logic                         busy_o
);

    localparam int QS  = q_sum(Q_DAT, Q_OFFSET);
    localparam int LSB = lsb_pos(QS, Q_SCALE, SCALE_IN, NFRAC_OUT);
    localparam int DW  = DAT_BITS + QS - Q_DAT;
    localparam int OW  = OFFSET_BITS + QS - Q_OFFSET;
    localparam int SW  = ((DW > OW) ? DW : OW) + 1;
    localparam int PW  = SW + SCALE_BITS + 1;
    localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

    logic [SCALE_BITS-1:0]         scale_st, scale_a, scl_s1, scl_s2;
    logic signed [OFFSET_BITS-1:0] offset_st, offset_a, off_s1;
    logic [NSAMP*DAT_BITS-1:0]     dat_s1;
    logic                          en_s1, en_s2;
    logic signed [SW-1:0]          sum_s2  [NSAMP];
    logic signed [PW-1:0]          prod_s3 [NSAMP];

    // Apply samples the staged value before any same-edge write lands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scale_st    <= '0;
            offset_st   <= '0;
            scale_a     <= '0;
            offset_a    <= '0;
            apply_ack_o <= 1'b0;
        end else begin
            if (scale_wr_i) scale_st <= scale_i;
            if (offset_wr_i) offset_st <= offset_i;
            if (apply_req_i) begin
                scale_a  <= scale_st;
                offset_a <= offset_st;
            end
            apply_ack_o <= apply_req_i;
        end
    end

    // Coefficients travel with each word so a whole word always sees one coefficient set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_s1 <= '0;
            en_s1  <= 1'b0;
            en_s2  <= 1'b0;
            scl_s1 <= '0;
            scl_s2 <= '0;
            off_s1 <= '0;
            for (int k = 0; k < NSAMP; k++) begin
                sum_s2[k]  <= '0;
                prod_s3[k] <= '0;
            end
        end else begin
            dat_s1 <= dat_i;
            en_s1  <= en_i;
            en_s2  <= en_s1;
            scl_s1 <= scale_a;
            scl_s2 <= scl_s1;
            off_s1 <= offset_a;
            for (int k = 0; k < NSAMP; k++) begin
                sum_s2[k]  <= (SW'($signed(dat_s1[k*DAT_BITS +: DAT_BITS])) <<< (QS - Q_DAT))
                            + (SW'(off_s1) <<< (QS - Q_OFFSET));
                prod_s3[k] <= en_s2 ? PW'(sum_s2[k]) * PW'($signed({1'b0, scl_s2})) : '0;
            end
        end
    end

    for (genvar i = 0; i < NSAMP; i++) begin : g_lane
        agc_lane_sat #(
            .PW    (PW),
            .LSB   (LSB),
            .NBITS (NBITS)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .prod     (prod_s3[i]),
            .lane_out (out_o[i*NBITS +: NBITS]),
            .mag      (abs_o[i*(NBITS-1) +: NBITS-1]),
            .gt       (gt_o[i]),
            .lt       (lt_o[i])
        );
    end

    cnt_state_t          state, state_n;
    logic [CNT_BITS-1:0] rem, rem_n, hi_acc, hi_n, lo_acc, lo_n;
    logic [CNT_BITS:0]   hi_sum, lo_sum;

    always_comb begin
        state_n = state;
        rem_n   = rem;
        hi_n    = hi_acc;
        lo_n    = lo_acc;
        hi_sum  = {1'b0, hi_acc} + (CNT_BITS+1)'($countones(gt_o));
        lo_sum  = {1'b0, lo_acc} + (CNT_BITS+1)'($countones(lt_o));
        case (state)
            IDLE: if (win_start_i) begin
                state_n = COUNT;
                rem_n   = (win_len_i == '0) ? ONE : win_len_i;
                hi_n    = '0;
                lo_n    = '0;
            end
            COUNT: begin
                hi_n    = hi_sum[CNT_BITS] ? '1 : hi_sum[CNT_BITS-1:0];
                lo_n    = lo_sum[CNT_BITS] ? '1 : lo_sum[CNT_BITS-1:0];
                rem_n   = rem - ONE;
                state_n = (rem == ONE) ? DONE : COUNT;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rem         <= '0;
            hi_acc      <= '0;
            lo_acc      <= '0;
            hi_cnt_o    <= '0;
            lo_cnt_o    <= '0;
            cnt_valid_o <= 1'b0;
        end else begin
            state       <= state_n;
            rem         <= rem_n;
            hi_acc      <= hi_n;
            lo_acc      <= lo_n;
            hi_cnt_o    <= (state == DONE) ? hi_acc : hi_cnt_o;
            lo_cnt_o    <= (state == DONE) ? lo_acc : lo_cnt_o;
            cnt_valid_o <= (state == DONE);
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_agc_multilane_scaler.sv
// tb_agc_multilane_scaler: directed and randomized checks of the multilane AGC scaler
// against an arithmetic reference model and hand-computed literals.
module tb_agc_multilane_scaler;

    localparam int NS = 8;
    localparam int DB = 12;
    localparam int OB = 16;
    localparam int NB = 5;
    localparam int CB = 16;
    localparam int HN = 4096;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  en_i = 1'b0;
    logic [NS*DB-1:0]      dat_i = '0;
    logic [16:0]           scale_i = '0;
    logic                  scale_wr_i = 1'b0;
    logic [OB-1:0]         offset_i = '0;
    logic                  offset_wr_i = 1'b0;
    logic                  apply_req_i = 1'b0;
    logic                  apply_ack_o;
    logic [NS*NB-1:0]      out_o;
    logic [NS*(NB-1)-1:0]  abs_o;
    logic [NS-1:0]         gt_o, lt_o;
    logic [CB-1:0]         win_len_i = '0;
    logic                  win_start_i = 1'b0;
    logic [CB-1:0]         hi_cnt_o, lo_cnt_o;
    logic                  cnt_valid_o, busy_o;

    agc_multilane_scaler dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en_i),
        .dat_i       (dat_i),
        .scale_i     (scale_i),
        .scale_wr_i  (scale_wr_i),
        .offset_i    (offset_i),
        .offset_wr_i (offset_wr_i),
        .apply_req_i (apply_req_i),
        .apply_ack_o (apply_ack_o),
        .out_o       (out_o),
        .abs_o       (abs_o),
        .gt_o        (gt_o),
        .lt_o        (lt_o),
        .win_len_i   (win_len_i),
        .win_start_i (win_start_i),
        .hi_cnt_o    (hi_cnt_o),
        .lo_cnt_o    (lo_cnt_o),
        .cnt_valid_o (cnt_valid_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // (dat*2^8 + offset) * scale, floored at 2^-23
    function automatic longint lane_raw(input int d, input int off, input int sc);
        return ((longint'(d) * 256 + longint'(off)) * longint'(sc)) >>> 23;
    endfunction

    logic [NS*NB-1:0]     h_out [HN];
    logic [NS*(NB-1)-1:0] h_abs [HN];
    logic [NS-1:0]        h_gt  [HN];
    logic [NS-1:0]        h_lt  [HN];
    int  m_sc_st, m_sc_a, m_off_st, m_off_a;
    int  e_hi, e_lo, acc_hi, acc_lo, ws, wl;
    bit  pend, e_valid, e_ack;

    // Reference model: expected outputs per sampled word, plus the window schedule.
    initial forever begin
        int n, idx, d, o, a;
        longint raw;
        @(posedge clk);
        n = cyc;
        idx = n % HN;
        if (rst) begin
            h_out[idx] = '0; h_abs[idx] = '0; h_gt[idx] = '0; h_lt[idx] = '0;
            m_sc_st = 0; m_sc_a = 0; m_off_st = 0; m_off_a = 0;
            e_hi = 0; e_lo = 0; pend = 0; e_valid = 0; e_ack = 0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                d = int'($signed(dat_i[k*DB +: DB]));
                raw = en_i ? lane_raw(d, m_off_a, m_sc_a) : 0;
                o = (raw > 15) ? 15 : (raw < -16) ? -16 : int'(raw);
                a = (o < 0) ? ((o == -16) ? 15 : -o) : o;
                h_out[idx][k*NB +: NB] = NB'(o);
                h_abs[idx][k*(NB-1) +: NB-1] = (NB-1)'(a);
                h_gt[idx][k] = raw > 15;
                h_lt[idx][k] = raw < -16;
            end
            e_valid = 0;
            if (pend) begin
                if (n <= ws + wl && n >= 4) begin
                    acc_hi = acc_hi + $countones(h_gt[(n-4) % HN]);
                    acc_lo = acc_lo + $countones(h_lt[(n-4) % HN]);
                    if (acc_hi > 65535) acc_hi = 65535;
                    if (acc_lo > 65535) acc_lo = 65535;
                end
                if (n == ws + wl + 1) begin
                    e_hi = acc_hi; e_lo = acc_lo; e_valid = 1; pend = 0;
                end
            end else if (win_start_i) begin
                pend = 1; ws = n; wl = (win_len_i == 0) ? 1 : int'(win_len_i);
                acc_hi = 0; acc_lo = 0;
            end
            e_ack = apply_req_i;
            if (apply_req_i) begin
                m_sc_a = m_sc_st;
                m_off_a = m_off_st;
            end
            if (scale_wr_i) m_sc_st = int'(scale_i);
            if (offset_wr_i) m_off_st = int'($signed(offset_i));
        end
        cyc = n + 1;
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        int m, i;
        @(negedge clk);
        if (cyc > 0) begin
            m = cyc - 1;
            if (rst) begin
                chk("rst_out", out_o, 0);
                chk("rst_gtlt", {gt_o, lt_o}, 0);
                chk("rst_cnt", {hi_cnt_o, lo_cnt_o, cnt_valid_o, busy_o, apply_ack_o}, 0);
            end else begin
                if (m >= 3) begin
                    i = (m - 3) % HN;
                    chk("out", out_o, h_out[i]);
                    chk("abs", abs_o, h_abs[i]);
                    chk("gt", gt_o, h_gt[i]);
                    chk("lt", lt_o, h_lt[i]);
                end
                chk("ack", apply_ack_o, e_ack);
                chk("cnt_valid", cnt_valid_o, e_valid);
                chk("hi_cnt", hi_cnt_o, e_hi);
                chk("lo_cnt", lo_cnt_o, e_lo);
                chk("busy", busy_o, pend);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < NS; k++) dat_i[k*DB +: DB] = DB'(v);
    endtask

    task automatic set_coef(input int sc, input int off);
        scale_i = 17'(sc); offset_i = OB'(off);
        scale_wr_i = 1; offset_wr_i = 1;
        tick();
        scale_wr_i = 0; offset_wr_i = 0; apply_req_i = 1;
        tick();
        apply_req_i = 0;
        chk("apply_ack", apply_ack_o, 1);
        tick();
        chk("ack_pulse", apply_ack_o, 0);
    endtask

    task automatic run_window(input int len, input int span, input string nm, input int hi, input int lo);
        int pulses;
        pulses = 0;
        win_len_i = CB'(len); win_start_i = 1;
        tick();
        win_start_i = 0;
        chk({nm, "_busy"}, busy_o, 1);
        for (int t = 0; t < span; t++) begin
            tick();
            pulses += int'(cnt_valid_o);
        end
        chk({nm, "_pulses"}, pulses, 1);
        chk({nm, "_hi"}, hi_cnt_o, hi);
        chk({nm, "_lo"}, lo_cnt_o, lo);
        chk({nm, "_idle"}, busy_o, 0);
    endtask

    task automatic clip_pattern();
        set_all(0);
        for (int k = 0; k < 3; k++) dat_i[k*DB +: DB] = DB'(200);
        for (int k = 3; k < 5; k++) dat_i[k*DB +: DB] = DB'(-200);
    endtask

    initial begin
        int pulses;
        chk("model_64", lane_raw(64, 0, 4096), 8);
        chk("model_m1", lane_raw(-1, 0, 4096), -1);
        chk("model_off16", lane_raw(16, 4096, 4096), 4);
        chk("model_200", lane_raw(200, 4096, 4096), 27);
        chk("model_m200", lane_raw(-200, 4096, 4096), -23);
        repeat (3) tick();
        chk("reset_out", out_o, 0);
        chk("reset_state", {busy_o, cnt_valid_o, hi_cnt_o, lo_cnt_o}, 0);
        repeat (2) tick();
        rst = 0; en_i = 1;
        tick();

        set_coef(4096, 0);
        set_all(64);   repeat (5) tick();
        chk("d64_out", out_o, {NS{5'd8}});
        chk("d64_abs", abs_o, {NS{4'd8}});
        set_all(32);   repeat (5) tick();
        chk("d32_out", out_o, {NS{5'd4}});
        set_all(-1);   repeat (5) tick();
        chk("dm1_out", out_o, {NS{5'h1f}});
        chk("dm1_abs", abs_o, {NS{4'd1}});

        set_coef(4096, 4096);
        set_all(16);   repeat (5) tick();
        chk("off_out", out_o, {NS{5'd4}});
        set_all(200);  repeat (5) tick();
        chk("pos_sat_out", out_o, {NS{5'd15}});
        chk("pos_sat_gt", {gt_o, lt_o}, {8'hff, 8'h00});
        chk("pos_sat_abs", abs_o, {NS{4'd15}});
        set_all(-200); repeat (5) tick();
        chk("neg_sat_out", out_o, {NS{5'h10}});
        chk("neg_sat_lt", {gt_o, lt_o}, {8'h00, 8'hff});
        chk("neg_sat_abs", abs_o, {NS{4'd15}});

        set_coef(4096, 0);
        set_all(64);
        scale_i = 17'd8192; scale_wr_i = 1; apply_req_i = 1;
        tick();
        scale_wr_i = 0; apply_req_i = 0;
        repeat (6) tick();
        chk("wr_apply_same_cycle", out_o, {NS{5'd8}});
        apply_req_i = 1;
        tick();
        apply_req_i = 0;
        repeat (6) tick();
        chk("reapply_out", out_o, {NS{5'd15}});
        chk("reapply_gt", gt_o, 8'hff);

        set_coef(4096, 0);
        repeat (6) tick();
        en_i = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3) en_i = 1;
            chk($sformatf("en_low_%0d", k), out_o, (k >= 4 && k <= 6) ? '0 : {NS{5'd8}});
        end

        clip_pattern();
        repeat (6) tick();
        run_window(10, 20, "win10", 30, 20);
        run_window(0, 6, "win0", 3, 2);

        win_len_i = 10; win_start_i = 1;
        tick();
        win_start_i = 0;
        repeat (4) tick();
        rst = 1;
        pulses = 0;
        repeat (4) begin
            tick();
            pulses += int'(cnt_valid_o);
        end
        chk("rst_mid_counts", {hi_cnt_o, lo_cnt_o}, 0);
        chk("rst_mid_busy", busy_o, 0);
        rst = 0;
        repeat (14) begin
            tick();
            pulses += int'(cnt_valid_o);
        end
        chk("rst_mid_no_pulse", pulses, 0);
        set_coef(4096, 0);
        repeat (6) tick();
        run_window(10, 20, "win_after_rst", 30, 20);

        for (int t = 0; t < 800; t++) begin
            for (int k = 0; k < NS; k++) dat_i[k*DB +: DB] = DB'($urandom_range(0, 4095));
            en_i = ($urandom_range(0, 9) != 0);
            scale_wr_i = ($urandom_range(0, 7) == 0);
            scale_i = ($urandom_range(0, 3) == 0) ? 17'($urandom) : 17'($urandom_range(0, 8192));
            offset_wr_i = ($urandom_range(0, 7) == 0);
            offset_i = OB'($urandom);
            apply_req_i = ($urandom_range(0, 5) == 0);
            win_start_i = ($urandom_range(0, 9) == 0);
            win_len_i = CB'($urandom_range(0, 15));
            tick();
        end
        scale_wr_i = 0; offset_wr_i = 0; apply_req_i = 0; win_start_i = 0;
        repeat (30) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/agc_multilane_scaler.md
Name: agc_multilane_scaler

Overview:
NSAMP-lane successor to the single-sample AGC scale/offset slice. Each cycle it applies one shared (data + offset) × scale to every lane of a parallel sample word, truncates and saturates each lane to NBITS signed, and also produces a saturating absolute value. It adds a staged/apply coefficient handshake with acknowledge, and a windowed per-direction saturation counter that firmware uses to close the AGC loop. It sits between the sample-word unpacker and the trigger beamformer.

Parameters:
NSAMP, 8, lanes per clock
DAT_BITS, 12, signed input sample width
Q_DAT, 0, input fractional bits
OFFSET_BITS, 16, signed offset width
Q_OFFSET, 8, offset fractional bits
Q_SCALE, 12, scale fractional bits; scale is always 17-bit unsigned
SCALE_IN, 5, log2 of nominal input RMS
NFRAC_OUT, 2, output bits below RMS
NBITS, 5, signed output width
CNT_BITS, 16, window length and saturation-counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
en_i  in  1  enables datapath output; when low, the product pipeline is forced to 0
dat_i  in  NSAMP*DAT_BITS  lane k at [k*DAT_BITS +: DAT_BITS]
scale_i  in  17  staged scale value
scale_wr_i  in  1  write scale_i into the staged register
offset_i  in  OFFSET_BITS  staged offset value
offset_wr_i  in  1  write offset_i into the staged register
apply_req_i  in  1  copy staged registers into the active registers
apply_ack_o  out  1  one-cycle acknowledge of an apply
out_o  out  NSAMP*NBITS  saturated scaled lanes
abs_o  out  NSAMP*(NBITS-1)  per-lane absolute value, saturated
gt_o  out  NSAMP  lane clipped positive
lt_o  out  NSAMP  lane clipped negative
win_len_i  in  CNT_BITS  window length in cycles
win_start_i  in  1  start a counting window
hi_cnt_o  out  CNT_BITS  latched count of positive clips
lo_cnt_o  out  CNT_BITS  latched count of negative clips
cnt_valid_o  out  1  one-cycle pulse when the counts update
busy_o  out  1  a window is in progress

Behaviour:
- Reset: every output is 0; the staged and active scale/offset registers are 0; the FSM is in IDLE.
- Arithmetic:
  - Q_SUM = max(Q_DAT, Q_OFFSET).
  - Data and offset are each sign-extended and left-shifted so both carry Q_SUM fractional bits, then summed at full precision.
  - The sum is multiplied by {0, active scale}.
  - LSB = Q_SUM + Q_SCALE + SCALE_IN − NFRAC_OUT (23 at defaults).
  - Output is product[LSB +: NBITS], truncated (floor).
  - Saturation: if product bits above LSB+NBITS−2 are not all equal to the sign bit, the output is forced to +2^(NBITS−1)−1 with gt=1, or to −2^(NBITS−1) with lt=1.
  - abs = |out|, clamped to 2^(NBITS−1)−1.
- Latency: fixed 4 cycles from dat_i to out_o/abs_o/gt_o/lt_o (input register, sum/multiply register, product register, saturate register). Full throughput, no stalls.
- en_i low: the product register is cleared, so 4 cycles later out=0 and gt=lt=0.
- Coefficients:
  - scale_wr_i / offset_wr_i load the staged registers on the clock edge.
  - apply_req_i high copies staged to active on the same edge; apply_ack_o is high the following cycle.
  - If a write and apply_req_i occur in the same cycle, apply copies the pre-write staged value; the write lands in staged only.
  - The new coefficients affect all lanes of the sample word entering the pipeline the cycle after apply, never a partial word.
  - apply_req_i held high re-applies every cycle and ack follows every cycle.
- Saturation counter FSM:
  - IDLE: on win_start_i, load remaining = max(win_len_i, 1), clear the accumulators, go to COUNT; busy_o = 1.
  - COUNT: every cycle, hi_acc += popcount(gt_o) and lo_acc += popcount(lt_o), each saturating at 2^CNT_BITS−1; remaining decrements.
  - When remaining = 1, that cycle's popcounts are included, then the FSM goes to DONE.
  - win_start_i during COUNT is ignored.
  - DONE: hi_cnt_o/lo_cnt_o ← accumulators, cnt_valid_o = 1 for one cycle, return to IDLE.
  - win_start_i in DONE is ignored; it is accepted only in IDLE.
  - Counts hold until the next DONE.
  - Windows count regardless of en_i (while en_i is low, gt/lt are 0).
- Reset mid-window: the FSM returns to IDLE, counts clear, and no cnt_valid_o pulse is issued.

Decomposition:
- Shared package agc_pkg: Q_SUM/LSB computation functions, saturation mask generation, and the FSM state enum {IDLE, COUNT, DONE}.
- One sub-module, agc_lane_sat (one per lane, generate loop): it takes the product and outputs out/abs/gt/lt registered. It is the only per-lane logic; the coefficient registers and the FSM are shared.

Test Plan:
- Scale=4096, offset=0, apply; all lanes dat=64 → after apply_ack_o, out=8 on every lane 4 cycles later; dat=32 → 4; dat=−1 → −1 (floor).
- Offset=4096 (16.0), scale=4096; dat=16 → out=4. Then dat=200 → out=15, gt=1, abs=15. Then dat=−200 → out=−16, lt=1, abs=15.
- Write scale=8192 in the same cycle as apply_req with staged=4096 → active=4096 (dat=64 gives 8); apply again → dat=64 gives 15, saturated.
- en_i low for 3 cycles with dat=64 → out=0 for exactly 3 consecutive cycles, starting 4 cycles after en_i falls.
- win_len=10; lanes 0–2 dat=200, lanes 3–4 dat=−200 for the whole window → cnt_valid_o pulses once, hi_cnt=30, lo_cnt=20. win_len=0 → window of 1 cycle.
- Assert rst_i at cycle 5 of a 10-cycle window → no cnt_valid_o, counts=0, busy_o=0; a new window started afterwards completes normally.
